// File: rtl/mul_seq_if.sv
// Start/ready handshake between the ex stage and the sequential multiplier.
// The requester drives operands and controls; the multiplier returns the product and ready.
interface mul_seq_if #(
    parameter int WIDTH = 32
);
    logic               signed_mul_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic               start_i;
    logic               annul_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;

    modport master (
        output signed_mul_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_mul_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/mul_seq.sv
// Radix-2 shift-add multiplier for MULT/MULTU, one partial product per clock.
// Works on operand magnitudes and applies the sign to the final product.
//
// state | meaning
// IDLE  | waiting for start_i; zero operands short-cut straight to DONE
// BUSY  | one shift-add step per edge until WIDTH steps are done
// DONE  | ready_o high, product held until start_i drops or annul_i
module mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    mul_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_sum;
    logic [2*WIDTH-1:0] result_r;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [CW-1:0]      counter;
    logic               neg;
    logic               ready_r;

    // 0x80..0 negates to itself, which is exactly 2^(WIDTH-1) when read unsigned.
    always_comb begin
        mag1 = (bus.signed_mul_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
        mag2 = (bus.signed_mul_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;
        acc_sum = mplier[0] ? (acc + mcand) : acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            neg      <= 1'b0;
            counter  <= '0;
            result_r <= '0;
            ready_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready_r  <= 1'b0;
                    result_r <= '0;
                    if (bus.start_i && !bus.annul_i) begin
                        if (bus.opdata1_i == '0 || bus.opdata2_i == '0) begin
                            state   <= DONE;
                            ready_r <= 1'b1;
                        end else begin
                            mcand   <= {{WIDTH{1'b0}}, mag1};
                            mplier  <= mag2;
                            acc     <= '0;
                            neg     <= bus.signed_mul_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
                            counter <= '0;
                            state   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (bus.annul_i) begin
                        state    <= IDLE;
                        acc      <= '0;
                        ready_r  <= 1'b0;
                        result_r <= '0;
                    end else begin
                        acc     <= acc_sum;
                        mcand   <= mcand << 1;
                        mplier  <= mplier >> 1;
                        counter <= counter + CW'(1);
                        if (counter == CW'(WIDTH - 1)) begin
                            state    <= DONE;
                            ready_r  <= 1'b1;
                            result_r <= neg ? -acc_sum : acc_sum;
                        end
                    end
                end
                DONE: begin
                    if (!bus.start_i || bus.annul_i) begin
                        state    <= IDLE;
                        ready_r  <= 1'b0;
                        result_r <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.result_o = result_r;
    assign bus.ready_o  = ready_r;
endmodule
